// File: rtl/mc_burst_drain.sv
// Drains beats from the data buffer into a staging array and
// issues them as one DRAM write burst (command phase, then data phase).
module mc_burst_drain #(
    parameter int DATA_WIDTH = 64,
    parameter int BURST_LEN  = 8,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  buf_empty,
    input  logic [DATA_WIDTH-1:0] buf_data,
    output logic                  buf_rd_req,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic                  addr_load,
    input  logic                  flush,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    output logic [3:0]            cmd_len,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_last,
    output logic                  busy
);

    localparam int IW    = $clog2(BURST_LEN);
    localparam int CW    = IW + 1;
    localparam int BYTES = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        FILL,
        CMD,
        DATA
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         fill_cnt_q, fill_cnt_d;
    logic [IW-1:0]         beat_idx_q, beat_idx_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  flush_pend_q, flush_pend_d;
    logic                  rd_inflight_q, rd_inflight_d;
    logic [DATA_WIDTH-1:0] staging_q [BURST_LEN];

    logic [CW-1:0] len_m1;
    logic          idle_fill;
    logic          go_cmd;
    logic          last_beat;

    always_comb begin
        state_d      = state_q;
        fill_cnt_d   = fill_cnt_q;
        beat_idx_d   = beat_idx_q;
        addr_d       = addr_q;
        flush_pend_d = flush_pend_q | flush;
        buf_rd_req   = 1'b0;
        cmd_valid    = 1'b0;
        cmd_addr     = '0;
        cmd_len      = '0;
        wr_valid     = 1'b0;
        wr_data      = '0;
        wr_last      = 1'b0;
        go_cmd       = 1'b0;
        last_beat    = 1'b0;

        len_m1    = fill_cnt_q - CW'(1);
        idle_fill = (fill_cnt_q == '0) && !rd_inflight_q;

        if (rd_inflight_q) begin
            fill_cnt_d = fill_cnt_q + CW'(1);
        end
        // A flush with nothing staged or in flight has nothing to send.
        if (flush && idle_fill) begin
            flush_pend_d = 1'b0;
        end

        unique case (state_q)
            FILL: begin
                go_cmd = (fill_cnt_d == CW'(BURST_LEN)) ||
                         (flush_pend_q && (fill_cnt_q != '0) &&
                          !rd_inflight_q);
                // Suppressing the read on the leaving cycle keeps
                // a late beat from landing outside FILL.
                buf_rd_req = reset && enable && !buf_empty && !go_cmd &&
                             ((fill_cnt_q + CW'(rd_inflight_q)) <
                              CW'(BURST_LEN));
                if (addr_load && idle_fill) begin
                    addr_d = start_addr;
                end
                if (go_cmd) begin
                    state_d      = CMD;
                    flush_pend_d = 1'b0;
                end
            end
            CMD: begin
                cmd_valid = 1'b1;
                cmd_addr  = addr_q;
                cmd_len   = 4'(len_m1);
                if (cmd_ready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                wr_valid  = 1'b1;
                wr_data   = staging_q[beat_idx_q];
                last_beat = ({1'b0, beat_idx_q} == len_m1);
                wr_last   = last_beat;
                if (wr_ready) begin
                    if (last_beat) begin
                        addr_d = addr_q +
                                 ADDR_WIDTH'(fill_cnt_q) *
                                 ADDR_WIDTH'(BYTES);
                        fill_cnt_d = '0;
                        beat_idx_d = '0;
                        state_d    = FILL;
                    end else begin
                        beat_idx_d = beat_idx_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase

        rd_inflight_d = buf_rd_req;
    end

    assign busy = (state_q != FILL) || (fill_cnt_q != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= FILL;
            fill_cnt_q    <= '0;
            beat_idx_q    <= '0;
            addr_q        <= '0;
            flush_pend_q  <= 1'b0;
            rd_inflight_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fill_cnt_q    <= fill_cnt_d;
            beat_idx_q    <= beat_idx_d;
            addr_q        <= addr_d;
            flush_pend_q  <= flush_pend_d;
            rd_inflight_q <= rd_inflight_d;
        end
    end

    // Staged beats are only read below fill_cnt, so no reset is needed.
    always_ff @(posedge clk) begin
        if (rd_inflight_q) begin
            staging_q[fill_cnt_q[IW-1:0]] <= buf_data;
        end
    end

endmodule

// File: tb/tb_mc_burst_drain.sv
// Scoreboard bench for mc_burst_drain: a buffer model feeds beats,
// a negedge monitor checks commands, beats and stall stability.
module tb_mc_burst_drain;

    localparam int DW = 64;
    localparam int BL = 8;
    localparam int AW = 32;

    logic          clk        = 1'b0;
    logic          reset      = 1'b0;
    logic          enable     = 1'b1;
    logic          buf_empty  = 1'b1;
    logic [DW-1:0] buf_data   = '0;
    logic [AW-1:0] start_addr = '0;
    logic          addr_load  = 1'b0;
    logic          flush      = 1'b0;
    logic          cmd_ready  = 1'b1;
    logic          wr_ready   = 1'b1;
    logic          buf_rd_req;
    logic          cmd_valid;
    logic [AW-1:0] cmd_addr;
    logic [3:0]    cmd_len;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_last;
    logic          busy;

    always #5 clk = ~clk;

    mc_burst_drain #(
        .DATA_WIDTH(DW),
        .BURST_LEN (BL),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .buf_empty (buf_empty),
        .buf_data  (buf_data),
        .buf_rd_req(buf_rd_req),
        .start_addr(start_addr),
        .addr_load (addr_load),
        .flush     (flush),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .wr_last   (wr_last),
        .busy      (busy)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [3:0]    len;
    } cmd_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    int            checks      = 0;
    int            failures    = 0;
    int            beats_seen  = 0;
    int            bursts_done = 0;
    int            rd_req_cnt  = 0;
    logic [DW-1:0] bq[$];
    cmd_t          exp_cmd[$];
    beat_t         exp_beat[$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Buffer model: one-cycle read latency, registered empty flag.
    always @(posedge clk) begin
        if (buf_rd_req && bq.size() > 0) begin
            buf_data <= bq.pop_front();
        end
        buf_empty <= (bq.size() == 0);
    end

    always @(posedge clk) begin
        if (buf_rd_req) rd_req_cnt <= rd_req_cnt + 1;
    end

    logic          pc_stall = 1'b0;
    logic          pw_stall = 1'b0;
    logic [AW-1:0] p_addr   = '0;
    logic [3:0]    p_len    = '0;
    logic [DW-1:0] p_data   = '0;
    logic          p_last   = 1'b0;

    always @(negedge clk) begin
        cmd_t  c;
        beat_t b;
        if (!reset) begin
            pc_stall = 1'b0;
            pw_stall = 1'b0;
        end else begin
            if (cmd_valid || wr_valid) chk("rd_req_in_cmd_data", 64'(buf_rd_req), 0);
            if (buf_empty) chk("rd_req_while_empty", 64'(buf_rd_req), 0);
            if (pc_stall) begin
                chk("cmd_valid_held", 64'(cmd_valid), 1);
                chk("cmd_addr_stable", 64'(cmd_addr), 64'(p_addr));
                chk("cmd_len_stable", 64'(cmd_len), 64'(p_len));
            end
            if (pw_stall) begin
                chk("wr_valid_held", 64'(wr_valid), 1);
                chk("wr_data_stable", wr_data, p_data);
                chk("wr_last_stable", 64'(wr_last), 64'(p_last));
            end
            if (cmd_valid && cmd_ready) begin
                if (exp_cmd.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_cmd actual addr=0x%0h len=%0d required=none",
                             cmd_addr, cmd_len);
                end else begin
                    c = exp_cmd.pop_front();
                    chk("cmd_addr", 64'(cmd_addr), 64'(c.addr));
                    chk("cmd_len", 64'(cmd_len), 64'(c.len));
                end
            end
            if (wr_valid && wr_ready) begin
                beats_seen++;
                if (wr_last) bursts_done++;
                if (exp_beat.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual data=0x%0h required=none",
                             wr_data);
                end else begin
                    b = exp_beat.pop_front();
                    chk("wr_data", wr_data, b.data);
                    chk("wr_last", 64'(wr_last), 64'(b.last));
                end
            end
            pc_stall = cmd_valid && !cmd_ready;
            p_addr   = cmd_addr;
            p_len    = cmd_len;
            pw_stall = wr_valid && !wr_ready;
            p_data   = wr_data;
            p_last   = wr_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beats(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) bq.push_back(base + DW'(i));
    endtask

    task automatic exp_burst(input logic [AW-1:0] addr, input int n,
                             input logic [DW-1:0] base);
        cmd_t  c;
        beat_t b;
        c.addr = addr;
        c.len  = 4'(n - 1);
        exp_cmd.push_back(c);
        for (int i = 0; i < n; i++) begin
            b.data = base + DW'(i);
            b.last = (i == n - 1);
            exp_beat.push_back(b);
        end
    endtask

    task automatic wait_bursts(input int target, input string name);
        int k;
        k = 0;
        while (bursts_done < target && k < 300) begin
            tick();
            k++;
        end
        chk(name, 64'(bursts_done >= target), 1);
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        int k;
        int mark;
        int base;

        repeat (3) tick();
        chk("rst_cmd_valid", 64'(cmd_valid), 0);
        chk("rst_wr_valid", 64'(wr_valid), 0);
        chk("rst_wr_last", 64'(wr_last), 0);
        chk("rst_rd_req", 64'(buf_rd_req), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_cmd_addr", 64'(cmd_addr), 0);
        reset = 1'b1;
        tick();

        // Full burst at a loaded base address.
        start_addr = 32'h1000;
        addr_load  = 1'b1;
        tick();
        addr_load = 1'b0;
        exp_burst(32'h1000, 8, 64'hA0);
        push_beats(64'hA0, 8);
        wait_bursts(1, "burst1_done");

        // Partial burst by flush.
        exp_burst(32'h1040, 3, 64'hB0);
        push_beats(64'hB0, 3);
        repeat (8) tick();
        chk("partial_no_cmd_yet", 64'(cmd_valid), 0);
        chk("partial_busy", 64'(busy), 1);
        pulse_flush();
        wait_bursts(2, "burst2_done");

        // Command and data stalls.
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        exp_burst(32'h1058, 8, 64'hC0);
        push_beats(64'hC0, 8);
        k = 0;
        while (!cmd_valid && k < 50) begin
            tick();
            k++;
        end
        chk("stall_cmd_seen", 64'(cmd_valid), 1);
        repeat (5) tick();
        cmd_ready = 1'b1;
        tick();
        k = 0;
        while (bursts_done < 3 && k < 200) begin
            wr_ready = ~wr_ready;
            tick();
            k++;
        end
        chk("burst3_done", 64'(bursts_done >= 3), 1);
        wr_ready = 1'b1;

        // Buffer runs dry after one beat, then refills.
        exp_burst(32'h1098, 8, 64'hD0);
        push_beats(64'hD0, 1);
        repeat (6) tick();
        chk("dry_busy", 64'(busy), 1);
        chk("dry_no_cmd", 64'(cmd_valid), 0);
        push_beats(64'hD1, 7);
        wait_bursts(4, "burst4_done");

        // Flush with nothing staged is dropped; flush on the filling beat.
        tick();
        chk("idle_busy", 64'(busy), 0);
        pulse_flush();
        exp_burst(32'h10D8, 8, 64'hE0);
        push_beats(64'hE0, 1);
        repeat (6) tick();
        chk("flush_ignored", 64'(cmd_valid), 0);
        mark = rd_req_cnt;
        push_beats(64'hE1, 7);
        k = 0;
        while (rd_req_cnt < mark + 7 && k < 50) begin
            tick();
            k++;
        end
        chk("eighth_read_seen", 64'(rd_req_cnt >= mark + 7), 1);
        pulse_flush();
        wait_bursts(5, "burst5_done");
        repeat (10) tick();
        chk("single_full_burst", 64'(exp_cmd.size()), 0);
        chk("no_extra_cmd", 64'(cmd_valid), 0);

        // Asynchronous reset in the middle of the data phase.
        exp_burst(32'h1118, 8, 64'hF0);
        push_beats(64'hF0, 8);
        base = beats_seen;
        k = 0;
        while (beats_seen < base + 4 && k < 100) begin
            tick();
            k++;
        end
        chk("mid_data_reached", 64'(wr_valid), 1);
        #1;
        reset = 1'b0;
        #1;
        chk("arst_cmd_valid", 64'(cmd_valid), 0);
        chk("arst_wr_valid", 64'(wr_valid), 0);
        chk("arst_wr_data", wr_data, 0);
        chk("arst_wr_last", 64'(wr_last), 0);
        chk("arst_busy", 64'(busy), 0);
        chk("arst_rd_req", 64'(buf_rd_req), 0);
        exp_cmd.delete();
        exp_beat.delete();
        repeat (2) tick();
        reset = 1'b1;
        tick();
        chk("post_rst_busy", 64'(busy), 0);
        chk("post_rst_cmd_valid", 64'(cmd_valid), 0);
        exp_burst(32'h0, 2, 64'h50);
        push_beats(64'h50, 2);
        repeat (6) tick();
        pulse_flush();
        wait_bursts(bursts_done + 1, "post_rst_burst_done");

        repeat (5) tick();
        chk("exp_queues_empty", 64'(exp_cmd.size() + exp_beat.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule

// File: doc/mc_burst_drain.md
Name: mc_burst_drain

Overview:
- Downstream consumer of the memory-controller data buffer. Pops beats through the buffer's read_request/data_out/buffer_empty interface.
- Gathers up to BURST_LEN beats in an internal staging array, then issues one write burst to the DRAM-side write channel.
- The write channel is a command phase (valid/ready) followed by a data phase (valid/ready/last).
- Generates incrementing burst addresses and supports a flush that sends a partial burst.

Parameters:
DATA_WIDTH, 64, beat width; must match the data buffer.
BURST_LEN, 8, maximum beats per burst; power of two, 2..16.
ADDR_WIDTH, 32, byte-address width.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-low reset.
enable  input  1  when 0, no new buffer reads; handshakes in progress continue.
buf_empty  input  1  buffer_empty from the data buffer.
buf_data  input  DATA_WIDTH  data_out from the data buffer.
buf_rd_req  output  1  read_request to the data buffer.
start_addr  input  ADDR_WIDTH  base byte address.
addr_load  input  1  loads start_addr into the address counter.
flush  input  1  pulse; request a partial burst.
cmd_valid  output  1  burst command valid.
cmd_ready  input  1  command accepted.
cmd_addr  output  ADDR_WIDTH  burst start byte address.
cmd_len  output  4  beats minus 1.
wr_valid  output  1  write beat valid.
wr_ready  input  1  write beat accepted.
wr_data  output  DATA_WIDTH  write beat.
wr_last  output  1  final beat of the burst.
busy  output  1  high in CMD or DATA, or while staging is non-empty.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=FILL; fill_cnt=0; beat_idx=0; addr=0; flush_pend=0; rd_inflight=0.
  - All outputs 0.
- FSM states: FILL, CMD, DATA.
- FILL, buffer read:
  - buf_rd_req = enable & !buf_empty & (fill_cnt + rd_inflight < BURST_LEN); combinational.
  - rd_inflight is registered as buf_rd_req.
  - buf_data is captured into staging[fill_cnt] in the cycle after a request, when rd_inflight=1. fill_cnt increments at the same time.
  - One-cycle buffer read latency is fixed.
  - buf_empty is sampled as registered by the buffer; no read is requested while it is 1.
- FILL to CMD when either:
  - fill_cnt reaches BURST_LEN; or
  - flush_pend=1, fill_cnt>0 and rd_inflight=0.
- Flush handling:
  - flush sets flush_pend.
  - flush_pend clears on entry to CMD, or when flush arrives with fill_cnt=0 and rd_inflight=0 (nothing to send; ignored).
  - flush in the same cycle the staging fills yields a normal full burst, and flush_pend clears.
- CMD:
  - cmd_valid=1; cmd_addr=addr; cmd_len=fill_cnt-1.
  - All stay stable until cmd_ready. On the cycle cmd_valid&cmd_ready, go to DATA.
- DATA:
  - wr_valid=1; wr_data=staging[beat_idx]; wr_last=(beat_idx==fill_cnt-1).
  - Outputs stay stable while wr_ready=0.
  - Each accepted beat increments beat_idx.
  - On the accepted last beat:
    - addr += fill_cnt*(DATA_WIDTH/8), modulo 2^ADDR_WIDTH;
    - fill_cnt=0; beat_idx=0; return to FILL.
- No buffer reads are issued in CMD or DATA.
- addr_load takes effect only in FILL with fill_cnt=0 and rd_inflight=0; otherwise it is ignored (no queuing).
- Address wrap past 2^ADDR_WIDTH is silent; no burst is split.
- enable=0 in FILL:
  - stops new requests;
  - an in-flight beat is still captured;
  - a pending flush still proceeds.
- Reset mid-burst aborts the burst. Staged data is discarded and the address returns to 0.

Test Plan:
- Reset, addr_load start_addr=0x1000, push 8 beats 0xA0..0xA7 into the buffer; cmd_ready=wr_ready=1 -> one command cmd_addr=0x1000, cmd_len=7; beats 0xA0..0xA7 in order; wr_last only on 0xA7; next cmd_addr=0x1040.
- Push 3 beats, then pulse flush -> cmd_len=2 at the current address; 3 beats with wr_last on the third; address advances by 24.
- Hold cmd_ready=0 for 5 cycles, then toggle wr_ready every other cycle -> cmd_addr/cmd_len and wr_data/wr_last stable while stalled; no buf_rd_req in CMD or DATA; no beat lost or duplicated.
- Buffer runs empty after 1 beat with rd_inflight=1 -> capture completes; no read while buf_empty=1; fill resumes when the buffer refills; burst issued at 8 beats.
- flush with an empty staging array -> no command, flush_pend=0. flush in the cycle the 8th beat is captured -> a single full burst, cmd_len=7.
- Assert reset low in DATA at beat 4 -> all outputs 0 immediately (async); after release, state=FILL, addr=0, busy=0.
